// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  localparam int unsigned LOADER_LEN_BYTES  = 2;
  localparam int unsigned LOADER_WORD_BYTES = 4;

  localparam logic [31:0] LOADER_DEFAULT_BASE = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Shifts accepted stream bytes into a little-endian 32-bit word; flags the last byte of each word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready_c
);

  localparam int unsigned CNT_W = $clog2(LOADER_WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(LOADER_WORD_BYTES - 1);

  logic [CNT_W-1:0] cnt;

  assign word_ready_c = en && (cnt == LAST_BYTE);

  // New bytes enter at the top so the first byte ends up least significant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (en) begin
      cnt  <= cnt + CNT_W'(1);
      word <= {byte_in, word[31:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> sequential instruction-memory writes, then core release.
// Optional trailing mod-256 payload checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = LOADER_DEFAULT_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int unsigned CNT_W     = LOADER_LEN_BYTES * 8;
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  loader_state_t    state;
  logic [7:0]       n_lo;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_next;
  logic [CNT_W-1:0] n_hdr;
  logic             accept;
  logic             word_ready_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       sum;
`endif

  assign accept   = rx_valid && rx_ready;
  assign n_hdr    = {rx_data, n_lo};
  assign idx_next = idx + CNT_W'(1);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear        (accept && (state == ST_LEN1)),
    .en           (accept && (state == ST_DATA)),
    .byte_in      (rx_data),
    .word         (imem_wdata),
    .word_ready_c (word_ready_c)
  );

  // Outputs are updated alongside each state transition so they always decode the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_LEN0;
      n_lo      <= '0;
      n_words   <= '0;
      idx       <= '0;
      rx_ready  <= 1'b1;
      imem_we   <= 1'b0;
      imem_addr <= BASE_ADDR;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        ST_LEN0: begin
          if (accept) begin
            n_lo  <= rx_data;
            state <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (accept) begin
            n_words <= n_hdr;
            if (32'(n_hdr) > MAX_WORDS) begin
              state    <= ST_ERR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
            end else if (n_hdr == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state     <= ST_CSUM;
`else
              state     <= ST_DONE;
              rx_ready  <= 1'b0;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
`endif
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) sum <= sum + rx_data;
`endif
          if (word_ready_c) begin
            state    <= ST_WRITE;
            imem_we  <= 1'b1;
            rx_ready <= 1'b0;
          end
        end
        ST_WRITE: begin
          idx       <= idx_next;
          imem_addr <= imem_addr + 32'd4;
          if (idx_next == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= ST_CSUM;
            rx_ready <= 1'b1;
`else
            state     <= ST_DONE;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
`endif
          end else begin
            state    <= ST_DATA;
            rx_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == sum) begin
              state     <= ST_DONE;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

  localparam int unsigned AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: derived from the stream contents only.
  bit [7:0]    stream[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] seen_addr[$];
  logic [31:0] seen_data[$];
  bit          checking = 1'b0;
  int          nacc, end_acc, end_lag, term_cnt, n_words;
  bit          we_due, terminal, exp_ok;

  task automatic plan_load();
    int n;
    bit [7:0] s;
    n = 32'({stream[1], stream[0]});
    exp_addr_q.delete();
    exp_data_q.delete();
    seen_addr.delete();
    seen_data.delete();
    nacc = 0; we_due = 1'b0; terminal = 1'b0; term_cnt = 0; n_words = n;
    if (n > (1 << AW)) begin
      exp_ok = 1'b0; end_acc = 2; end_lag = 1;
    end else begin
      s = 8'h00;
      for (int w = 0; w < n; w++) begin
        exp_addr_q.push_back(BASE + 32'(4 * w));
        exp_data_q.push_back({stream[2+4*w+3], stream[2+4*w+2], stream[2+4*w+1], stream[2+4*w]});
        for (int k = 0; k < 4; k++) s = s + stream[2+4*w+k];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      end_acc = 2 + 4 * n + 1;
      end_lag = 1;
      exp_ok  = (stream[end_acc-1] == s);
`else
      end_acc = 2 + 4 * n;
      end_lag = (n == 0) ? 1 : 2;
      exp_ok  = 1'b1;
`endif
    end
    checking = 1'b1;
  endtask

  // Per-cycle compare, then advance the model by the handshake seen this cycle.
  bit cmp_ready;
  int cmp_p;
  initial begin
    forever begin
      @(negedge clk);
      if (checking && !reset) begin
        cmp_ready = !(we_due || terminal);
        chk("imem_we", 32'(imem_we), 32'(we_due));
        chk("rx_ready", 32'(rx_ready), 32'(cmp_ready));
        chk("done", 32'(done), 32'(terminal && exp_ok));
        chk("error", 32'(error), 32'(terminal && !exp_ok));
        chk("cpu_reset", 32'(cpu_reset), 32'(!(terminal && exp_ok)));
        if (imem_we) begin
          seen_addr.push_back(imem_addr);
          seen_data.push_back(imem_wdata);
        end
        if (we_due && exp_addr_q.size() > 0) begin
          chk("imem_addr", imem_addr, exp_addr_q.pop_front());
          chk("imem_wdata", imem_wdata, exp_data_q.pop_front());
        end
        we_due = 1'b0;
        if (term_cnt > 0) begin
          term_cnt--;
          if (term_cnt == 0) terminal = 1'b1;
        end
        if (rx_valid && cmp_ready) begin
          cmp_p = nacc - 2;
          nacc++;
          if (cmp_p >= 0 && cmp_p < 4 * n_words && (cmp_p % 4) == 3) we_due = 1'b1;
          if (nacc == end_acc) begin
            if (end_lag == 1) terminal = 1'b1;
            else term_cnt = end_lag - 1;
          end
        end
      end
    end
  end

  task automatic send_byte(input bit [7:0] b, input int pct);
    int cyc;
    bit acc;
    cyc = 0; acc = 1'b0;
    while (!acc && cyc < 300) begin
      rx_data  = b;
      rx_valid = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      acc = rx_valid && rx_ready;
      @(posedge clk); #1;
      cyc++;
    end
    rx_valid = 1'b0;
    chk("byte_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_n(input int cnt, input int pct);
    for (int i = 0; i < cnt; i++) send_byte(stream[i], pct);
  endtask

  task automatic offer_ignored(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rx_data = 8'($urandom); rx_valid = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_terminal();
    int c;
    c = 0;
    while (!terminal && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("terminal_reached", 32'(terminal), 32'd1);
  endtask

  task automatic run_load(input int pct);
    plan_load();
    send_n(end_acc, pct);
    wait_terminal();
    offer_ignored(4);
  endtask

  task automatic do_reset();
    checking = 1'b0;
    rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", imem_addr, BASE);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic load_test1();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h96);
`endif
  endtask

  task automatic pin_test1(input string tag);
    chk({tag, "_nwrites"}, 32'(seen_addr.size()), 32'd2);
    if (seen_addr.size() == 2) begin
      chk({tag, "_w0_addr"}, seen_addr[0], 32'h0000_0000);
      chk({tag, "_w0_data"}, seen_data[0], 32'h0050_0013);
      chk({tag, "_w1_addr"}, seen_addr[1], 32'h0000_0004);
      chk({tag, "_w1_data"}, seen_data[1], 32'h00A0_0093);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit [7:0] b, s;

    do_reset();

    // Normal load with continuous valid.
    load_test1();
    run_load(100);
    pin_test1("t1");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: writes still happen, then sticky error.
    do_reset();
    load_test1();
    stream[10] = 8'h97;
    run_load(100);
    chk("t2_nwrites", 32'(seen_addr.size()), 32'd2);
    chk("t2_error", 32'(error), 32'd1);
    chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t2_rx_ready", 32'(rx_ready), 32'd0);
`endif

    // Empty load.
    do_reset();
    stream = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    run_load(100);
    chk("t3_nwrites", 32'(seen_addr.size()), 32'd0);
    chk("t3_done", 32'(done), 32'd1);

    // Length overflow (N = 0x401).
    do_reset();
    stream = '{8'h01, 8'h04, 8'h13, 8'h00};
    run_load(100);
    chk("t4_nwrites", 32'(seen_addr.size()), 32'd0);
    chk("t4_error", 32'(error), 32'd1);

    // Backpressure and random gaps.
    do_reset();
    load_test1();
    run_load(50);
    pin_test1("t5");

    // Reset after the first write, then replay the whole stream.
    do_reset();
    load_test1();
    plan_load();
    send_n(6, 100);
    n = 0;
    while (!imem_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_write", 32'(imem_we), 32'd1);
    @(posedge clk); #1;
    checking = 1'b0;
    reset = 1'b1;
    #2;
    chk("t6_async_addr", imem_addr, BASE);
    chk("t6_async_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t6_async_rx_ready", 32'(rx_ready), 32'd1);
    do_reset();
    run_load(70);
    pin_test1("t6");

    // Randomized loads.
    for (int it = 0; it < 10; it++) begin
      do_reset();
      n = $urandom_range(1, 12);
      stream.delete();
      stream.push_back(8'(n));
      stream.push_back(8'(n >> 8));
      s = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        stream.push_back(b);
        s = s + b;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream.push_back(($urandom_range(0, 3) == 0) ? 8'(s + 8'd1) : s);
`endif
      run_load($urandom_range(40, 100));
      chk("rand_nwrites", 32'(seen_addr.size()), 32'(n));
    end

    // Largest legal image, then one word too many.
    for (int big = 1024; big <= 1025; big++) begin
      do_reset();
      stream.delete();
      stream.push_back(8'(big));
      stream.push_back(8'(big >> 8));
      if (big == 1024) begin
        s = 8'h00;
        for (int i = 0; i < 4 * big; i++) begin
          b = 8'($urandom);
          stream.push_back(b);
          s = s + b;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(s);
`endif
      end
      run_load(100);
      if (big == 1024) begin
        chk("max_nwrites", 32'(seen_addr.size()), 32'd1024);
        if (seen_addr.size() == 1024) chk("max_last_addr", seen_addr[1023], 32'h0000_0FFC);
        chk("max_done", 32'(done), 32'd1);
      end else begin
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_nwrites", 32'(seen_addr.size()), 32'd0);
      end
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that drives the instruction-memory write port. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to sequential instruction-memory addresses starting at `BASE_ADDR`. The core is held in reset until the load completes, and the optional checksum must pass before the core is released.

## Interface
- `ADDR_WIDTH`, 10: instruction-memory word-address bits; capacity is 2**ADDR_WIDTH words.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: reset is asynchronous and active-high.
- `rx_data` input 8: incoming stream byte.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: loader accepts a byte this cycle; transfer occurs when `rx_valid && rx_ready`.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_addr` output 32: byte address of the write, word aligned.
- `imem_wdata` output 32: word to write.
- `cpu_reset` output 1: holds the core in reset while high.
- `done` output 1: load finished successfully; sticky.
- `error` output 1: load failed; sticky.

## Operation
- Stream format:
  - N low byte, then N high byte (16-bit word count).
  - 4*N payload bytes, least-significant byte first per word.
  - One checksum byte, only when the macro is enabled.
- States:
  - LEN0: accepts the N low byte.
  - LEN1: accepts the N high byte. If N > 2**ADDR_WIDTH, go to ERR. If N == 0, go to CSUM (or DONE without the macro). Otherwise go to DATA.
  - DATA: accepts bytes into the assembler. The 4th byte of a word goes to WRITE.
  - WRITE: `imem_we`=1. Word index is incremented. If index == N, go to CSUM/DONE; else go to DATA.
  - CSUM: accepts one byte and compares it with the running sum. Match goes to DONE, mismatch goes to ERR.
  - DONE and ERR are terminal until `reset`.
- Output decode by state:
  - `rx_ready`=1 in LEN0, LEN1, DATA, CSUM; 0 in WRITE, DONE, ERR.
  - `cpu_reset`=0 only in DONE.
  - `done`=1 only in DONE; `error`=1 only in ERR.
- Address and data:
  - `imem_addr` = BASE_ADDR + 4*index, with 32-bit wrap.
  - `imem_wdata` = {b3,b2,b1,b0}.
  - Both are registered and stable throughout the WRITE cycle.
- Bytes offered while `rx_ready`=0 are not consumed; the sender holds them.
- Reset values: state LEN0, `rx_ready`=1, `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `cpu_reset`=1, `done`=0, `error`=0. Index, byte count and sum are all 0.
- Reset mid-load: everything returns to the reset values immediately, and the next accepted byte is treated as N low. Words already written are not erased.

## Timing
- Each word costs at least 5 cycles: 4 accepts plus 1 WRITE.
- `imem_we` asserts the cycle after the 4th byte of a word is accepted.
- `cpu_reset` falls, and `done` rises, the cycle after the final WRITE (no macro) or after the checksum accept (macro).
- `error` rises the cycle after the offending LEN1 or CSUM accept.
- `rx_valid` may drop for any number of cycles in any accepting state; assembly resumes without loss.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CSUM state exists.
  - Running sum = mod-256 sum of payload bytes only; length bytes are excluded.
  - A mismatch gives ERR.
- Undefined:
  - No CSUM state and no sum register.
  - The final WRITE (or LEN1 with N==0) goes directly to DONE.
  - ERR is reachable only through length overflow.

## Structure
- `imem_loader_pkg` holds:
  - the state enum typedef;
  - `LOADER_LEN_BYTES`=2 and `LOADER_WORD_BYTES`=4;
  - the opcode-independent default BASE_ADDR.
- One sub-module, `word_assembler`:
  - shifts accepted bytes into a 32-bit little-endian register;
  - 2-bit byte counter;
  - `word_ready` on the 4th byte;
  - synchronous clear.

## Test plan
- Normal load, macro on, stream 02 00 13 00 50 00 93 00 A0 00 96:
  - writes 0x00500013 @0x0 and 0x00A00093 @0x4;
  - then `done`=1, `cpu_reset`=0.
- Same stream with checksum 0x97:
  - both writes occur;
  - `error`=1, `cpu_reset` stays 1, `rx_ready`=0; further bytes are ignored.
- Empty load, stream 00 00 00: no `imem_we`, then `done`=1.
- Overflow with ADDR_WIDTH=10, stream 01 04 (N=0x401): `error`=1 one cycle after the second accept, and no writes occur.
- Backpressure and gaps, test-1 stream:
  - `rx_valid` is deasserted randomly and a byte is presented during each WRITE cycle;
  - those bytes are accepted the following cycle;
  - writes are identical to test 1.
- Reset mid-load: assert `reset` after the first WRITE of test 1, then replay the full stream → writes restart at 0x0 and `done`=1.
